inst_fetcher: RTL and testbench

Front-end stage directly upstream of the decoder. It fetches 32-bit instructions in order from the instruction memory/icache port and buffers them in a small instruction queue. It presents the queue head to the decoder as valid/inst_addr/inst, holds the head while the decoder stalls, and flushes and redirects when the decoder requests a new PC (JAL/JALR/branch).

---
 rtl/inst_fetcher.sv | 146 ++++++++++++++
 tb/tb_inst_fetcher.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetcher.sv
// Purpose : in-order instruction fetch front end with a small instruction queue feeding the decoder.
// Latency : request accepted in cycle N, response in N+1 is queued at end of N+1, head valid in N+2.
// Backpressure: if_stall holds the queue head; a full queue stops new requests; rdy_in low freezes all state.
//
// Ports:
//   clk_in, rst_in (async, active high), rdy_in (global enable)
//   mem_req_valid/mem_req_ready/mem_req_addr : fetch request channel, one request outstanding at most
//   mem_resp_valid/mem_resp_data             : response for the outstanding request
//   valid/inst_addr/inst                     : queue head presented to the decoder
//   if_stall, if_clear, if_set_addr          : decoder hold, flush and redirect target
// Optional build macro IF_PERF_CNT_EN adds perf_stall_cycles and perf_flush_count outputs.
module inst_fetcher #(
    parameter int          IQ_WIDTH_BIT = 2,
    parameter logic [31:0] RESET_ADDR   = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        valid,
    output logic [31:0] inst_addr,
    output logic [31:0] inst,
    input  logic        if_stall,
    input  logic        if_clear,
    input  logic [31:0] if_set_addr
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_count
`endif
);

    localparam int                  DEPTH    = 1 << IQ_WIDTH_BIT;
    localparam logic [IQ_WIDTH_BIT:0] LP_DEPTH = (IQ_WIDTH_BIT + 1)'(DEPTH);

    logic [31:0]             r_fetch_pc;
    logic [31:0]             r_req_pc;
    logic                    r_outstanding;
    logic                    r_drop;
    logic [IQ_WIDTH_BIT-1:0] r_head;
    logic [IQ_WIDTH_BIT-1:0] r_tail;
    logic [IQ_WIDTH_BIT:0]   r_count;
    logic [31:0]             r_q_pc   [DEPTH];
    logic [31:0]             r_q_inst [DEPTH];

    logic w_full;
    logic w_req_fire;
    logic w_resp;
    logic w_push;
    logic w_pop;

    assign w_full = (r_count == LP_DEPTH);

    // Only request when a slot is guaranteed free for the response, so the queue can never overflow.
    assign mem_req_valid = !rst_in && !r_outstanding && !w_full && !if_clear;
    assign mem_req_addr  = r_fetch_pc;

    // Handshakes only count in cycles where the pipeline is enabled.
    assign w_req_fire = rdy_in && mem_req_valid && mem_req_ready;
    assign w_resp     = rdy_in && mem_resp_valid && r_outstanding;
    // A response belonging to a flushed request (drop) or arriving during a flush is discarded.
    assign w_push     = w_resp && !r_drop && !if_clear;

    assign valid     = (r_count != '0) && !if_clear;
    assign w_pop     = rdy_in && valid && !if_stall;
    assign inst_addr = r_q_pc[r_head];
    assign inst      = r_q_inst[r_head];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_fetch_pc    <= RESET_ADDR;
            r_req_pc      <= RESET_ADDR;
            r_outstanding <= 1'b0;
            r_drop        <= 1'b0;
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_q_pc[i]   <= '0;
                r_q_inst[i] <= '0;
            end
        end else if (rdy_in) begin
            // A request can only fire with nothing outstanding, so fire and response never collide here.
            if (w_req_fire) begin
                r_outstanding <= 1'b1;
                r_req_pc      <= r_fetch_pc;
            end else if (w_resp) begin
                r_outstanding <= 1'b0;
            end

            // drop marks the in-flight request as stale; its response retires it either way.
            if (w_resp) begin
                r_drop <= 1'b0;
            end else if (if_clear && r_outstanding) begin
                r_drop <= 1'b1;
            end

            if (if_clear) begin
                r_fetch_pc <= if_set_addr & ~32'h3;
            end else if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end

            if (if_clear) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_q_pc[r_tail]   <= r_req_pc;
                    r_q_inst[r_tail] <= mem_resp_data;
                    r_tail           <= r_tail + 1'b1;
                end
                if (w_pop) begin
                    r_head <= r_head + 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            perf_stall_cycles <= '0;
            perf_flush_count  <= '0;
        end else if (rdy_in) begin
            if (valid && if_stall) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (if_clear) begin
                perf_flush_count <= perf_flush_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetcher.sv
module tb_inst_fetcher;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        valid;
    logic [31:0] inst_addr;
    logic [31:0] inst;
    logic        if_stall;
    logic        if_clear;
    logic [31:0] if_set_addr;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_flush_count;
`endif

    int checks = 0;
    int errors = 0;

    // memory model state
    logic        resp_hold;
    logic        pending;
    logic [31:0] pend_addr;
    logic        acc;
    logic        cons;
    logic [31:0] acc_addr;

    always #5 clk_in = ~clk_in;

    inst_fetcher dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_ready (mem_req_ready),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data (mem_resp_data),
        .valid         (valid),
        .inst_addr     (inst_addr),
        .inst          (inst),
        .if_stall      (if_stall),
        .if_clear      (if_clear),
        .if_set_addr   (if_set_addr)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_stall_cycles(perf_stall_cycles),
        .perf_flush_count (perf_flush_count)
`endif
    );

    // Memory: answers one cycle after an accepted request with data = addr ^ 0xDEAD0000.
    // resp_hold delays the answer; an answer is retired only in an rdy_in cycle.
    initial begin
        pending        = 1'b0;
        pend_addr      = '0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
    end

    always @(posedge clk_in) begin
        acc      = !rst_in && rdy_in && mem_req_valid && mem_req_ready;
        cons     = rdy_in && mem_resp_valid;
        acc_addr = mem_req_addr;
        #1;
        if (rst_in) begin
            pending = 1'b0;
        end else begin
            if (cons) pending = 1'b0;
            if (acc) begin
                pending   = 1'b1;
                pend_addr = acc_addr;
            end
        end
        mem_resp_valid = pending && !resp_hold;
        mem_resp_data  = pending ? (pend_addr ^ 32'hDEAD_0000) : 32'h0;
    end

    task automatic do_reset();
        rst_in        = 1'b1;
        rdy_in        = 1'b1;
        mem_req_ready = 1'b1;
        if_stall      = 1'b0;
        if_clear      = 1'b0;
        if_set_addr   = '0;
        resp_hold     = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    task automatic wait_valid(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk_in);
            if (valid) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_in        = 1'b1;
        rdy_in        = 1'b1;
        mem_req_ready = 1'b1;
        if_stall      = 1'b0;
        if_clear      = 1'b0;
        if_set_addr   = '0;
        resp_hold     = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %b want 0", mem_req_valid); end
        checks++; if (mem_req_addr !== 32'h0) begin errors++; $display("FAIL reset_req_addr got %h want 00000000", mem_req_addr); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
        checks++; if (inst_addr !== 32'h0) begin errors++; $display("FAIL reset_inst_addr got %h want 00000000", inst_addr); end
        checks++; if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst got %h want 00000000", inst); end
    endtask

    task automatic test_basic();
        bit ok;
        logic [31:0] exp_pc;
        do_reset();
        // first accept happens at the next edge
        @(negedge clk_in);
        checks++; if (valid !== 1'b0 || mem_req_valid !== 1'b0) begin errors++; $display("FAIL basic_n1 got valid=%b req=%b want 0 0", valid, mem_req_valid); end
        @(negedge clk_in);
        checks++; if (valid !== 1'b1 || inst_addr !== 32'h0 || inst !== 32'hDEAD_0000) begin
            errors++; $display("FAIL basic_first got valid=%b addr=%h inst=%h want 1 00000000 dead0000", valid, inst_addr, inst); end
        checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h4) begin
            errors++; $display("FAIL basic_req2 got valid=%b addr=%h want 1 00000004", mem_req_valid, mem_req_addr); end
        for (int k = 1; k <= 2; k++) begin
            exp_pc = 32'(k * 4);
            wait_valid(6, ok);
            checks++; if (!ok || inst_addr !== exp_pc || inst !== (exp_pc ^ 32'hDEAD_0000)) begin
                errors++; $display("FAIL basic_seq got ok=%b addr=%h inst=%h want addr=%h", ok, inst_addr, inst, exp_pc); end
        end
    endtask

    task automatic test_stall();
        bit ok;
        logic [31:0] exp_pc;
        do_reset();
        wait_valid(6, ok);
        wait_valid(6, ok);
        checks++; if (!ok || inst_addr !== 32'h4) begin errors++; $display("FAIL stall_head got ok=%b addr=%h want 00000004", ok, inst_addr); end
        if_stall = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_in);
            checks++; if (valid !== 1'b1 || inst_addr !== 32'h4 || inst !== 32'hDEAD_0004) begin
                errors++; $display("FAIL stall_hold[%0d] got valid=%b addr=%h want 1 00000004", i, valid, inst_addr); end
            if (i >= 5) begin
                checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_full_noreq[%0d] got %b want 0", i, mem_req_valid); end
            end
        end
        if_stall = 1'b0;
        for (int k = 2; k <= 5; k++) begin
            exp_pc = 32'(k * 4);
            wait_valid(3, ok);
            checks++; if (!ok || inst_addr !== exp_pc || inst !== (exp_pc ^ 32'hDEAD_0000)) begin
                errors++; $display("FAIL stall_release got ok=%b addr=%h want %h", ok, inst_addr, exp_pc); end
        end
    endtask

    task automatic test_clear();
        bit ok;
        logic [31:0] exp_pc;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            exp_pc = 32'(k * 4);
            wait_valid(6, ok);
            checks++; if (!ok || inst_addr !== exp_pc) begin errors++; $display("FAIL clear_pre got ok=%b addr=%h want %h", ok, inst_addr, exp_pc); end
        end
        if_stall = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h10) begin
            errors++; $display("FAIL clear_req10 got valid=%b addr=%h want 1 00000010", mem_req_valid, mem_req_addr); end
        resp_hold = 1'b1;
        @(negedge clk_in);
        checks++; if (valid !== 1'b1 || inst_addr !== 32'h8) begin errors++; $display("FAIL clear_q2 got valid=%b addr=%h want 1 00000008", valid, inst_addr); end
        if_clear    = 1'b1;
        if_set_addr = 32'h0000_0103;
        #1;
        checks++; if (valid !== 1'b0 || mem_req_valid !== 1'b0) begin
            errors++; $display("FAIL clear_cycle got valid=%b req=%b want 0 0", valid, mem_req_valid); end
        @(negedge clk_in);
        if_clear  = 1'b0;
        if_stall  = 1'b0;
        resp_hold = 1'b0;
        #1;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL clear_flushed got valid=%b want 0", valid); end
        @(negedge clk_in);
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL clear_wait_resp got req=%b want 0", mem_req_valid); end
        @(negedge clk_in);
        checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h100 || valid !== 1'b0) begin
            errors++; $display("FAIL clear_redirect got req=%b addr=%h valid=%b want 1 00000100 0", mem_req_valid, mem_req_addr, valid); end
        wait_valid(6, ok);
        checks++; if (!ok || inst_addr !== 32'h100 || inst !== 32'hDEAD_0100) begin
            errors++; $display("FAIL clear_target got ok=%b addr=%h inst=%h want 00000100 dead0100", ok, inst_addr, inst); end
    endtask

    task automatic test_clear_resp();
        bit ok;
        do_reset();
        if_stall = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        @(negedge clk_in);
        checks++; if (valid !== 1'b1 || inst_addr !== 32'h0) begin errors++; $display("FAIL clrresp_pre got valid=%b addr=%h want 1 00000000", valid, inst_addr); end
        if_clear    = 1'b1;
        if_set_addr = 32'h0000_0200;
        #1;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL clrresp_cycle got valid=%b want 0", valid); end
        @(negedge clk_in);
        if_clear = 1'b0;
        if_stall = 1'b0;
        #1;
        checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h200 || valid !== 1'b0) begin
            errors++; $display("FAIL clrresp_redirect got req=%b addr=%h valid=%b want 1 00000200 0", mem_req_valid, mem_req_addr, valid); end
        wait_valid(6, ok);
        checks++; if (!ok || inst_addr !== 32'h200 || inst !== 32'hDEAD_0200) begin
            errors++; $display("FAIL clrresp_target got ok=%b addr=%h inst=%h want 00000200 dead0200", ok, inst_addr, inst); end
    endtask

    task automatic test_backpressure();
        bit ok;
        do_reset();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0 || valid !== 1'b0) begin
                errors++; $display("FAIL bp_hold[%0d] got req=%b addr=%h valid=%b want 1 00000000 0", i, mem_req_valid, mem_req_addr, valid); end
        end
        mem_req_ready = 1'b1;
        wait_valid(6, ok);
        checks++; if (!ok || inst_addr !== 32'h0) begin errors++; $display("FAIL bp_first got ok=%b addr=%h want 00000000", ok, inst_addr); end
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            checks++; if (valid !== 1'b1 || inst_addr !== 32'h0 || inst !== 32'hDEAD_0000 || mem_req_valid !== 1'b1 || mem_req_addr !== 32'h4) begin
                errors++; $display("FAIL freeze[%0d] got valid=%b addr=%h inst=%h req=%b raddr=%h want 1 00000000 dead0000 1 00000004",
                                   i, valid, inst_addr, inst, mem_req_valid, mem_req_addr); end
        end
        rdy_in = 1'b1;
        wait_valid(6, ok);
        checks++; if (!ok || inst_addr !== 32'h4 || inst !== 32'hDEAD_0004) begin
            errors++; $display("FAIL resume_1 got ok=%b addr=%h want 00000004", ok, inst_addr); end
        wait_valid(6, ok);
        checks++; if (!ok || inst_addr !== 32'h8) begin errors++; $display("FAIL resume_2 got ok=%b addr=%h want 00000008", ok, inst_addr); end
    endtask

`ifdef IF_PERF_CNT_EN
    task automatic test_perf();
        bit ok;
        do_reset();
        checks++; if (perf_stall_cycles !== 32'd0 || perf_flush_count !== 32'd0) begin
            errors++; $display("FAIL perf_init got %0d %0d want 0 0", perf_stall_cycles, perf_flush_count); end
        wait_valid(6, ok);
        if_stall = 1'b1;
        repeat (3) @(negedge clk_in);
        if_stall = 1'b0;
        checks++; if (perf_stall_cycles !== 32'd3) begin errors++; $display("FAIL perf_stall got %0d want 3", perf_stall_cycles); end
        @(negedge clk_in);
        if_clear    = 1'b1;
        if_set_addr = 32'h40;
        @(negedge clk_in);
        if_clear = 1'b0;
        @(negedge clk_in);
        if_clear = 1'b1;
        @(negedge clk_in);
        if_clear = 1'b0;
        checks++; if (perf_flush_count !== 32'd2 || perf_stall_cycles !== 32'd3) begin
            errors++; $display("FAIL perf_flush got flush=%0d stall=%0d want 2 3", perf_flush_count, perf_stall_cycles); end
        rst_in = 1'b1;
        #1;
        checks++; if (perf_stall_cycles !== 32'd0 || perf_flush_count !== 32'd0) begin
            errors++; $display("FAIL perf_async_rst got %0d %0d want 0 0", perf_stall_cycles, perf_flush_count); end
        @(negedge clk_in);
        rst_in = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_clear();
        test_clear_resp();
        test_backpressure();
`ifdef IF_PERF_CNT_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
